// File: rtl/dvi_cap_pkg.sv
// Shared state encoding, error-bit indices and pixel widths for the DVI
// frame capture controller.
package dvi_cap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2
    } cap_state_e;

    localparam int ERR_OVF   = 0;
    localparam int ERR_SHORT = 1;

    localparam int RGB_W = 8;
    localparam int PIX_W = 3 * RGB_W;

endpackage

// File: rtl/dvi_cap_pix_counter.sv
// Pixel/line position counter for one active frame; flags the final pixel
// so the controller can close the frame on that write.
module dvi_cap_pix_counter #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] pix,
    output logic [CNT_W-1:0] line,
    output logic             last_pix_of_frame
);

    localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(H_ACT - 1);
    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(V_ACT - 1);

    assign last_pix_of_frame = (pix == PIX_LAST) && (line == LINE_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix  <= '0;
            line <= '0;
        end else if (clr) begin
            pix  <= '0;
            line <= '0;
        end else if (inc) begin
            if (pix == PIX_LAST) begin
                pix <= '0;
                // Line index saturates on the last line instead of wrapping.
                if (line != LINE_LAST) begin
                    line <= line + CNT_W'(1);
                end
            end else begin
                pix <= pix + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dvi_frame_capture_ctrl.sv
// Gates one H_ACT x V_ACT frame of DVI RX pixels into the frame-buffer write
// FIFO per capture request, aligned to vertical sync, with status reporting.
module dvi_frame_capture_ctrl
    import dvi_cap_pkg::*;
#(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int CNT_W = 12
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iSTART,
    input  logic             iCONTINUOUS,
    input  logic             iABORT,
    input  logic             iVS,
    input  logic             iDVAL,
    input  logic [RGB_W-1:0] iR,
    input  logic [RGB_W-1:0] iG,
    input  logic [RGB_W-1:0] iB,
    input  logic             iFIFO_FULL,
    output logic             oWR_EN,
    output logic [PIX_W-1:0] oWR_DATA,
    output logic             oBUSY,
    output logic             oFRAME_DONE,
    output logic [1:0]       oERR,
    output logic [15:0]      oFRAME_CNT,
    output logic [CNT_W-1:0] oLINE_CNT
);

    cap_state_e       state_q, state_d;
    logic             vs_q;
    logic             vs_fall;
    logic             pix_ok;
    logic             cnt_clr, cnt_inc;
    logic             last_pix;
    logic [CNT_W-1:0] pix_idx, line_idx;
    logic             wr_en_d, done_d;
    logic [1:0]       err_q, err_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    assign vs_fall = vs_q & ~iVS;
    assign pix_ok  = iDVAL & ~iFIFO_FULL;

    dvi_cap_pix_counter #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT),
        .CNT_W (CNT_W)
    ) u_pix_counter (
        .clk               (iCLK),
        .rst_n             (iRST_N),
        .clr               (cnt_clr),
        .inc               (cnt_inc),
        .pix               (pix_idx),
        .line              (line_idx),
        .last_pix_of_frame (last_pix)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        wr_en_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;

        if (iABORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iSTART) begin
                        state_d = ST_ARM;
                        err_d   = '0;
                    end
                end
                ST_ARM: begin
                    if (vs_fall) begin
                        state_d = ST_CAPTURE;
                        cnt_clr = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    // Completing write outranks a coincident vs_fall.
                    if (pix_ok && last_pix) begin
                        wr_en_d     = 1'b1;
                        cnt_inc     = 1'b1;
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = iCONTINUOUS ? ST_ARM : ST_IDLE;
                    end else if (vs_fall) begin
                        err_d[ERR_SHORT] = 1'b1;
                        cnt_clr          = 1'b1;
                    end else if (iDVAL && iFIFO_FULL) begin
                        err_d[ERR_OVF] = 1'b1;
                        state_d        = iCONTINUOUS ? ST_ARM : ST_IDLE;
                    end else if (pix_ok) begin
                        wr_en_d = 1'b1;
                        cnt_inc = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= ST_IDLE;
            vs_q        <= 1'b0;
            oWR_EN      <= 1'b0;
            oWR_DATA    <= '0;
            oFRAME_DONE <= 1'b0;
            err_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            vs_q        <= iVS;
            oWR_EN      <= wr_en_d;
            oFRAME_DONE <= done_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            if (wr_en_d) begin
                oWR_DATA <= {iR, iG, iB};
            end
        end
    end

    assign oBUSY      = (state_q != ST_IDLE);
    assign oERR       = err_q;
    assign oFRAME_CNT = frame_cnt_q;
    assign oLINE_CNT  = (state_q == ST_CAPTURE) ? line_idx : '0;

    // The pixel index never reaches H_ACT and the line never passes V_ACT-1.
    assert property (@(posedge iCLK) disable iff (!iRST_N) pix_idx < CNT_W'(H_ACT));
    assert property (@(posedge iCLK) disable iff (!iRST_N) line_idx < CNT_W'(V_ACT));

endmodule

// File: tb/tb_dvi_frame_capture_ctrl.sv
// Randomised self-checking bench for dvi_frame_capture_ctrl on an 8x4 frame,
// with a pixel-count reference model and a write scoreboard.
module tb_dvi_frame_capture_ctrl;

    localparam int H_ACT     = 8;
    localparam int V_ACT     = 4;
    localparam int CNT_W     = 12;
    localparam int FRAME_PIX = H_ACT * V_ACT;

    logic             iCLK = 1'b0;
    logic             iRST_N = 1'b1;
    logic             iSTART = 1'b0;
    logic             iCONTINUOUS = 1'b0;
    logic             iABORT = 1'b0;
    logic             iVS = 1'b1;
    logic             iDVAL = 1'b0;
    logic [7:0]       iR = '0, iG = '0, iB = '0;
    logic             iFIFO_FULL = 1'b0;
    logic             oWR_EN;
    logic [23:0]      oWR_DATA;
    logic             oBUSY;
    logic             oFRAME_DONE;
    logic [1:0]       oERR;
    logic [15:0]      oFRAME_CNT;
    logic [CNT_W-1:0] oLINE_CNT;

    dvi_frame_capture_ctrl #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT),
        .CNT_W (CNT_W)
    ) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iSTART      (iSTART),
        .iCONTINUOUS (iCONTINUOUS),
        .iABORT      (iABORT),
        .iVS         (iVS),
        .iDVAL       (iDVAL),
        .iR          (iR),
        .iG          (iG),
        .iB          (iB),
        .iFIFO_FULL  (iFIFO_FULL),
        .oWR_EN      (oWR_EN),
        .oWR_DATA    (oWR_DATA),
        .oBUSY       (oBUSY),
        .oFRAME_DONE (oFRAME_DONE),
        .oERR        (oERR),
        .oFRAME_CNT  (oFRAME_CNT),
        .oLINE_CNT   (oLINE_CNT)
    );

    always #5 iCLK = ~iCLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    // Reference model: where the capture is, how many pixels this frame has
    // accepted, and which writes must appear on which cycle.
    typedef enum {M_IDLE, M_ARM, M_CAP} mode_e;
    typedef struct {
        logic [23:0] data;
        logic        done;
        int          stamp;
    } wr_t;

    mode_e      m_mode = M_IDLE;
    int         m_idx = 0;
    int         m_frames = 0;
    logic [1:0] m_err = '0;
    logic       m_vs_prev = 1'b0;
    wr_t        exp_q[$];
    int         mon_wr_cnt = 0;
    int         mon_done_cnt = 0;
    wr_t        got_e;

    // Scoreboard: each write must match the next expected write on the same cycle.
    always @(posedge iCLK) begin
        #1;
        if (iRST_N) begin
            n_cmp++;
            if (oFRAME_DONE && !oWR_EN) begin
                n_bad++;
                $display("FAIL done_without_write: got oFRAME_DONE=1 oWR_EN=0, required done only with a write (cyc %0d)", cyc);
            end
            if (oFRAME_DONE) mon_done_cnt++;
            if (oWR_EN) begin
                mon_wr_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write: got data=%h done=%b at cyc %0d, required no write", oWR_DATA, oFRAME_DONE, cyc);
                end else begin
                    got_e = exp_q.pop_front();
                    if (oWR_DATA !== got_e.data || oFRAME_DONE !== got_e.done || cyc != got_e.stamp) begin
                        n_bad++;
                        $display("FAIL write_entry: got data=%h done=%b cyc=%0d, required data=%h done=%b cyc=%0d",
                                 oWR_DATA, oFRAME_DONE, cyc, got_e.data, got_e.done, got_e.stamp);
                    end
                end
            end
        end
    end

    // Applies one cycle of inputs, advances the model, and returns at the
    // following negedge when the DUT outputs reflect that cycle.
    task automatic drive(input logic dv, input logic vs, input logic full,
                         input logic start, input logic abort);
        logic [23:0] px;
        logic        fall;
        wr_t         e;
        px = 24'($urandom);
        iDVAL = dv; iVS = vs; iFIFO_FULL = full; iSTART = start; iABORT = abort;
        {iR, iG, iB} = px;
        fall = m_vs_prev && !vs;
        m_vs_prev = vs;
        if (abort) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (start) begin m_mode = M_ARM; m_err = '0; end
        end else if (m_mode == M_ARM) begin
            if (fall) begin m_mode = M_CAP; m_idx = 0; end
        end else begin
            if (dv && !full && m_idx + 1 == FRAME_PIX) begin
                e.data = px; e.done = 1'b1; e.stamp = cyc + 1;
                exp_q.push_back(e);
                m_frames++;
                m_mode = iCONTINUOUS ? M_ARM : M_IDLE;
            end else if (fall) begin
                m_err[1] = 1'b1;
                m_idx = 0;
            end else if (dv && full) begin
                m_err[0] = 1'b1;
                m_mode = iCONTINUOUS ? M_ARM : M_IDLE;
            end else if (dv) begin
                e.data = px; e.done = 1'b0; e.stamp = cyc + 1;
                exp_q.push_back(e);
                m_idx++;
            end
        end
        @(negedge iCLK);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic start_pulse();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic vs_pulse();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // n valid pixels with random idle gaps; FIFO full toggles only in gaps.
    task automatic pixels(input int n);
        int k;
        k = 0;
        while (k < n) begin
            if ($urandom_range(0, 3) == 0) begin
                drive(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0);
            end else begin
                drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                k++;
            end
        end
    endtask

    task automatic do_reset();
        iRST_N = 1'b0;
        iSTART = 1'b0; iABORT = 1'b0; iDVAL = 1'b0; iVS = 1'b1; iFIFO_FULL = 1'b0;
        @(negedge iCLK);
        @(negedge iCLK);
        m_mode = M_IDLE; m_idx = 0; m_frames = 0; m_err = '0; m_vs_prev = 1'b0;
        exp_q.delete();
        mon_wr_cnt = 0;
        mon_done_cnt = 0;
        iRST_N = 1'b1;
    endtask

    task automatic test_reset();
        logic [56:0] v;
        #1 iRST_N = 1'b0;
        #2;
        v = {oWR_EN, oWR_DATA, oBUSY, oFRAME_DONE, oERR, oFRAME_CNT, oLINE_CNT};
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, required 0", v);
        end
        do_reset();
        idle(3);
        n_cmp++;
        if (oBUSY !== 1'b0 || oWR_EN !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got busy=%b wr_en=%b, required 0/0", oBUSY, oWR_EN);
        end
    endtask

    task automatic test_single_shot();
        do_reset();
        iCONTINUOUS = 1'b0;
        start_pulse();
        idle(2);
        vs_pulse();
        pixels(FRAME_PIX);
        idle(3);
        n_cmp++;
        if (mon_wr_cnt != FRAME_PIX || mon_done_cnt != 1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL single_writes: got writes=%0d dones=%0d pending=%0d, required %0d/1/0",
                     mon_wr_cnt, mon_done_cnt, exp_q.size(), FRAME_PIX);
        end
        n_cmp++;
        if (oFRAME_CNT !== 16'd1 || oFRAME_CNT !== 16'(m_frames)) begin
            n_bad++;
            $display("FAIL single_frame_cnt: got %0d, required 1", oFRAME_CNT);
        end
        n_cmp++;
        if (oBUSY !== 1'b0 || oERR !== 2'b00) begin
            n_bad++;
            $display("FAIL single_status: got busy=%b err=%b, required 0/00", oBUSY, oERR);
        end
    endtask

    task automatic test_continuous();
        do_reset();
        iCONTINUOUS = 1'b1;
        start_pulse();
        for (int f = 0; f < 3; f++) begin
            idle(2);
            vs_pulse();
            pixels(FRAME_PIX);
            repeat (4) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (oBUSY !== 1'b1 || oLINE_CNT !== '0) begin
                n_bad++;
                $display("FAIL cont_between_frames: frame %0d got busy=%b line=%0d, required 1/0", f, oBUSY, oLINE_CNT);
            end
        end
        n_cmp++;
        if (oFRAME_CNT !== 16'd3 || oFRAME_CNT !== 16'(m_frames)) begin
            n_bad++;
            $display("FAIL cont_frame_cnt: got %0d, required 3", oFRAME_CNT);
        end
        n_cmp++;
        if (mon_wr_cnt != 3 * FRAME_PIX || mon_done_cnt != 3 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL cont_writes: got writes=%0d dones=%0d pending=%0d, required %0d/3/0",
                     mon_wr_cnt, mon_done_cnt, exp_q.size(), 3 * FRAME_PIX);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        iCONTINUOUS = 1'b1;
        start_pulse();
        idle(1);
        vs_pulse();
        pixels(9);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        pixels(5);
        n_cmp++;
        if (oERR !== 2'b01 || oERR !== m_err || mon_wr_cnt != 9 || mon_done_cnt != 0 || oBUSY !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_status: got err=%b writes=%0d dones=%0d busy=%b, required 01/9/0/1",
                     oERR, mon_wr_cnt, mon_done_cnt, oBUSY);
        end
        vs_pulse();
        pixels(FRAME_PIX);
        idle(2);
        n_cmp++;
        if (oERR !== 2'b01 || mon_wr_cnt != 9 + FRAME_PIX || mon_done_cnt != 1 || oFRAME_CNT !== 16'd1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL ovf_next_frame: got err=%b writes=%0d dones=%0d frames=%0d, required 01/%0d/1/1",
                     oERR, mon_wr_cnt, mon_done_cnt, oFRAME_CNT, 9 + FRAME_PIX);
        end
        start_pulse();
        n_cmp++;
        if (oERR !== 2'b01) begin
            n_bad++;
            $display("FAIL ovf_start_ignored: got err=%b, required 01", oERR);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        start_pulse();
        n_cmp++;
        if (oERR !== 2'b00 || oBUSY !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_err_clear: got err=%b busy=%b, required 00/1", oERR, oBUSY);
        end
    endtask

    task automatic test_short_frame();
        do_reset();
        iCONTINUOUS = 1'b0;
        start_pulse();
        idle(1);
        vs_pulse();
        pixels(20);
        n_cmp++;
        if (oLINE_CNT !== CNT_W'(2) || oLINE_CNT !== CNT_W'(m_idx / H_ACT)) begin
            n_bad++;
            $display("FAIL short_line_mid: got %0d, required 2", oLINE_CNT);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (oERR !== 2'b10 || oLINE_CNT !== '0 || oBUSY !== 1'b1) begin
            n_bad++;
            $display("FAIL short_restart: got err=%b line=%0d busy=%b, required 10/0/1", oERR, oLINE_CNT, oBUSY);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pixels(FRAME_PIX);
        idle(2);
        n_cmp++;
        if (oFRAME_CNT !== 16'd1 || mon_done_cnt != 1 || mon_wr_cnt != 20 + FRAME_PIX || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL short_complete: got frames=%0d dones=%0d writes=%0d, required 1/1/%0d",
                     oFRAME_CNT, mon_done_cnt, mon_wr_cnt, 20 + FRAME_PIX);
        end
        n_cmp++;
        if (oERR !== 2'b10 || oBUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL short_sticky: got err=%b busy=%b, required 10/0", oERR, oBUSY);
        end
    endtask

    task automatic test_vs_at_completion();
        do_reset();
        iCONTINUOUS = 1'b1;
        start_pulse();
        idle(1);
        vs_pulse();
        pixels(FRAME_PIX - 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (oFRAME_CNT !== 16'd1 || mon_done_cnt != 1 || mon_wr_cnt != FRAME_PIX || oBUSY !== 1'b1 || oERR !== 2'b00) begin
            n_bad++;
            $display("FAIL vs_at_done: got frames=%0d dones=%0d writes=%0d busy=%b err=%b, required 1/1/%0d/1/00",
                     oFRAME_CNT, mon_done_cnt, mon_wr_cnt, oBUSY, oERR, FRAME_PIX);
        end
        idle(1);
        vs_pulse();
        pixels(FRAME_PIX);
        idle(2);
        n_cmp++;
        if (oFRAME_CNT !== 16'd2 || oFRAME_CNT !== 16'(m_frames) || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL vs_at_done_next: got frames=%0d pending=%0d, required 2/0", oFRAME_CNT, exp_q.size());
        end
    endtask

    task automatic test_abort();
        do_reset();
        iCONTINUOUS = 1'b1;
        start_pulse();
        idle(1);
        vs_pulse();
        pixels(13);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (oBUSY !== 1'b0 || oWR_EN !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle: got busy=%b wr_en=%b, required 0/0", oBUSY, oWR_EN);
        end
        repeat (6) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vs_pulse();
        pixels(4);
        start_pulse();
        idle(1);
        vs_pulse();
        pixels(FRAME_PIX - 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);
        n_cmp++;
        if (mon_wr_cnt != 13 + FRAME_PIX - 1 || mon_done_cnt != 0 || oFRAME_CNT !== 16'd0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL abort_writes: got writes=%0d dones=%0d frames=%0d, required %0d/0/0",
                     mon_wr_cnt, mon_done_cnt, oFRAME_CNT, 13 + FRAME_PIX - 1);
        end
        n_cmp++;
        if (oBUSY !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_final_busy: got %b, required 0", oBUSY);
        end
    endtask

    task automatic test_async_reset();
        logic [56:0] v;
        do_reset();
        iCONTINUOUS = 1'b0;
        start_pulse();
        idle(1);
        vs_pulse();
        pixels(10);
        n_cmp++;
        if (oWR_EN !== 1'b1 || oBUSY !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_pre: got wr_en=%b busy=%b, required 1/1", oWR_EN, oBUSY);
        end
        #2 iRST_N = 1'b0;
        #1;
        v = {oWR_EN, oWR_DATA, oBUSY, oFRAME_DONE, oERR, oFRAME_CNT, oLINE_CNT};
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL areset_outputs: got %h, required 0", v);
        end
        do_reset();
        pixels(10);
        vs_pulse();
        pixels(10);
        idle(2);
        n_cmp++;
        if (mon_wr_cnt != 0 || oBUSY !== 1'b0 || oLINE_CNT !== '0) begin
            n_bad++;
            $display("FAIL areset_no_start: got writes=%0d busy=%b line=%0d, required 0/0/0",
                     mon_wr_cnt, oBUSY, oLINE_CNT);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_shot();
        test_continuous();
        test_overflow();
        test_short_frame();
        test_vs_at_completion();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
